// File: rtl/coproc_cmd_issuer_pkg.sv
// Shared types, widths and word encoding for the co-processor command issuer.
package coproc_pkg;

   localparam int OP_W   = 3;
   localparam int SRC_W  = 14;
   localparam int WORD_W = 32;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_MUL = 3'd4,
      OP_SLT = 3'd5,
      OP_SGT = 3'd6,
      OP_XOR = 3'd7
   } opcode_t;

   typedef struct packed {
      opcode_t          op;
      logic [SRC_W-1:0] src1;
      logic [SRC_W-1:0] src2;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // {op,src1,src2,par}; par makes the whole word even parity (^word == 0)
   function automatic logic [WORD_W-1:0] encode_word(input cmd_t c);
      logic [WORD_W-1:1] body;
      body = {c.op, c.src1, c.src2};
      return {body, ^body};
   endfunction

endpackage

// File: rtl/coproc_cmd_issuer_if.sv
// Host command channel plus co-processor FIFO write port.
// master = the issuer, slave = host / co-processor side.
interface coproc_cmd_issuer_if;
   import coproc_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   opcode_t          cmd_op;
   logic [SRC_W-1:0] cmd_src1;
   logic [SRC_W-1:0] cmd_src2;
   logic             full;
   logic             w_req;
   logic [WORD_W-1:0] data_in;

   modport master (
      input  cmd_valid, cmd_op, cmd_src1, cmd_src2, full,
      output cmd_ready, w_req, data_in
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_src1, cmd_src2, full,
      input  cmd_ready, w_req, data_in
   );

endinterface

// File: rtl/coproc_cmd_queue.sv
// Command queue: push on posedge, pop on negedge. Pointers carry an extra
// MSB so empty/full are distinguishable and level is a plain subtraction.
module coproc_cmd_queue
   import coproc_pkg::*;
#(
   parameter  int QDEPTH = 4,
   localparam int AW     = $clog2(QDEPTH)
) (
   input  logic        p_clk,
   input  logic        rst,
   input  logic        push,
   input  cmd_t        push_cmd,
   input  logic        pop,
   output cmd_t        head,
   output logic [AW:0] level,
   output logic        empty,
   output logic        fullq
);

   cmd_t        mem [QDEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   // Host-side write pointer advances on an accepted push
   always_ff @(posedge p_clk or negedge rst) begin
      if (!rst)
         wr_ptr <= '0;
      else if (push && !fullq)
         wr_ptr <= wr_ptr + 1'b1;
   end

   // Storage needs no reset; occupancy is defined by the pointers alone
   always_ff @(posedge p_clk) begin
      if (push && !fullq)
         mem[wr_ptr[AW-1:0]] <= push_cmd;
   end

   // Co-processor-side read pointer advances on a pop
   always_ff @(negedge p_clk or negedge rst) begin
      if (!rst)
         rd_ptr <= '0;
      else if (pop && !empty)
         rd_ptr <= rd_ptr + 1'b1;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign level = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign fullq = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/coproc_cmd_issuer.sv
// Co-processor result FIFO write master: queues host commands and issues
// one encoded word at most every second cycle from negedge flops.
module coproc_cmd_issuer
   import coproc_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     p_clk,
   input  logic                     rst,
   coproc_cmd_issuer_if.master      bus,
   output logic [$clog2(QDEPTH):0]  q_level,
   output logic [CNT_W-1:0]         issued_cnt,
   output logic [CNT_W-1:0]         stall_cnt
);

   state_t state;
   state_t state_nx;
   logic   issue;
   logic   stall;
   logic   push;
   logic   empty;
   logic   fullq;
   cmd_t   push_cmd;
   cmd_t   head;

   assign push_cmd  = '{op: bus.cmd_op, src1: bus.cmd_src1, src2: bus.cmd_src2};
   assign bus.cmd_ready = !fullq;
   assign push      = bus.cmd_valid && !fullq;

   coproc_cmd_queue #(.QDEPTH(QDEPTH)) u_queue (
      .p_clk    (p_clk),
      .rst      (rst),
      .push     (push),
      .push_cmd (push_cmd),
      .pop      (issue),
      .head     (head),
      .level    (q_level),
      .empty    (empty),
      .fullq    (fullq)
   );

   // FSM state register on the co-processor edge
   always_ff @(negedge p_clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Issue decision: ISSUE always forces a gap cycle so full can settle
   // after the co-processor's write before the next word is launched
   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      stall    = 1'b0;
      case (state)
         ST_IDLE, ST_GAP: begin
            state_nx = ST_IDLE;
            if (!empty) begin
               if (!bus.full) begin
                  issue    = 1'b1;
                  state_nx = ST_ISSUE;
               end else begin
                  stall = 1'b1;
               end
            end
         end
         ST_ISSUE: state_nx = ST_GAP;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Output word/strobe; data_in holds its last value between issues
   always_ff @(negedge p_clk or negedge rst) begin
      if (!rst) begin
         bus.w_req   <= 1'b0;
         bus.data_in <= '0;
      end else begin
         bus.w_req <= issue;
         if (issue)
            bus.data_in <= encode_word(head);
      end
   end

   // Saturating debug counters
   always_ff @(negedge p_clk or negedge rst) begin
      if (!rst) begin
         issued_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (issue && issued_cnt != '1)
            issued_cnt <= issued_cnt + 1'b1;
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_coproc_cmd_issuer.sv
// Bench: host pushes, a depth-32 co-processor FIFO model, and a word-order
// scoreboard computed from the field layout with plain arithmetic.
module tb_coproc_cmd_issuer;
   import coproc_pkg::*;

   localparam int QDEPTH   = 4;
   localparam int CNT_W    = 16;
   localparam int CF_DEPTH = 32;

   logic                    p_clk = 1'b0;
   logic                    rst   = 1'b0;
   logic [$clog2(QDEPTH):0] q_level;
   logic [CNT_W-1:0]        issued_cnt;
   logic [CNT_W-1:0]        stall_cnt;

   coproc_cmd_issuer_if bus ();

   coproc_cmd_issuer #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
      .p_clk      (p_clk),
      .rst        (rst),
      .bus        (bus),
      .q_level    (q_level),
      .issued_cnt (issued_cnt),
      .stall_cnt  (stall_cnt)
   );

   always #5 p_clk = ~p_clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference word: op*2^29 + src1*2^15 + src2*2, then even parity in bit 0
   function automatic logic [31:0] ref_word(input int op, input int s1, input int s2);
      longint      v;
      logic [31:0] w;
      v = longint'(op) * 536870912 + longint'(s1) * 32768 + longint'(s2) * 2;
      w = v[31:0];
      if ($countones(w) % 2 == 1) w = w + 1;
      return w;
   endfunction

   logic [31:0] exp_q[$];
   int          cf_cnt      = 0;
   int          cf_writes   = 0;
   int          cf_overflow = 0;
   bit          rd_en       = 1'b1;
   bit          force_full  = 1'b0;
   bit          pend        = 1'b0;
   bit          prev_wreq   = 1'b0;
   bit          host_done   = 1'b0;

   assign bus.full = force_full | (cf_cnt >= CF_DEPTH);

   // Co-processor: samples the word at posedge, reads randomly when enabled
   always @(posedge p_clk) begin
      if (rst && bus.w_req) begin
         chk("gap", 32'(prev_wreq), 0);
         chk("parity", 32'(^bus.data_in), 0);
         if (exp_q.size() == 0) chk("spurious", 32'(exp_q.size()), 1);
         else chk("word", bus.data_in, exp_q.pop_front());
         pend = 1'b1;
         cf_writes++;
      end
      prev_wreq = rst && bus.w_req;
      if (rd_en && cf_cnt > 0 && $urandom_range(0, 1) == 1) cf_cnt--;
   end

   // Co-processor: commits the sampled word at the following negedge
   always @(negedge p_clk) begin
      if (pend) begin
         pend = 1'b0;
         if (cf_cnt >= CF_DEPTH) cf_overflow++;
         else cf_cnt++;
      end
   end

   task automatic push(input int op, input int s1, input int s2, input int budget);
      int n = 0;
      @(negedge p_clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = opcode_t'(op);
      bus.cmd_src1  = 14'(s1);
      bus.cmd_src2  = 14'(s2);
      while (!bus.cmd_ready && n < budget) begin
         @(negedge p_clk); #1;
         n++;
      end
      if (!bus.cmd_ready) begin
         chk("push_timeout", 32'(bus.cmd_ready), 1);
         bus.cmd_valid = 1'b0;
      end else begin
         exp_q.push_back(ref_word(op, s1, s2));
         @(posedge p_clk); #1;
         bus.cmd_valid = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || pend) && n < 2000) begin
         @(negedge p_clk);
         n++;
      end
      chk({tag, "_drain"}, 32'(exp_q.size()), 0);
      repeat (3) @(negedge p_clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CNT_W-1:0] s0;
      logic [CNT_W-1:0] i0;
      int               w0;
      int               n;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_ADD;
      bus.cmd_src1  = '0;
      bus.cmd_src2  = '0;

      // reset state
      #27;
      chk("rst_wreq",   32'(bus.w_req), 0);
      chk("rst_data",   bus.data_in, 0);
      chk("rst_ready",  32'(bus.cmd_ready), 1);
      chk("rst_level",  32'(q_level), 0);
      chk("rst_issued", 32'(issued_cnt), 0);
      chk("rst_stall",  32'(stall_cnt), 0);
      #1 rst = 1'b1;

      // single ADD
      push(0, 5, 3, 50);
      drain("t1");
      chk("t1_data",   bus.data_in, 32'h0002_8006);
      chk("t1_issued", 32'(issued_cnt), 1);

      // full held with 2 queued for 5 negedges, then 4 queued and release
      s0 = stall_cnt;
      i0 = issued_cnt;
      @(posedge p_clk); #1;
      force_full = 1'b1;
      push(1, 100, 200, 50);
      push(2, 300, 400, 50);
      repeat (4) @(negedge p_clk);
      #2;
      chk("t2_stall",   32'(stall_cnt - s0), 5);
      chk("t2_noissue", 32'(issued_cnt - i0), 0);
      chk("t2_level2",  32'(q_level), 2);
      push(3, 16383, 0, 50);
      push(4, 1234, 4321, 50);
      chk("t2_level4",  32'(q_level), 4);
      chk("t2_ready0",  32'(bus.cmd_ready), 0);
      @(posedge p_clk); #1;
      force_full = 1'b0;
      drain("t2");
      chk("t2_issued",  32'(issued_cnt - i0), 4);
      chk("t2_level0",  32'(q_level), 0);
      chk("t2_ready1",  32'(bus.cmd_ready), 1);

      // XOR corner word, then one push per opcode
      push(7, 16'h3FFF, 1, 50);
      drain("t3x");
      chk("t3_op",     32'(bus.data_in[31:29]), 7);
      chk("t3_par",    32'(^bus.data_in), 0);
      for (int op = 0; op < 8; op++)
         push(op, $urandom_range(0, 16383), $urandom_range(0, 16383), 50);
      drain("t3");

      // reset while a word is on w_req and 3 remain queued
      @(posedge p_clk); #1;
      force_full = 1'b1;
      for (int k = 0; k < 4; k++)
         push($urandom_range(0, 7), $urandom_range(0, 16383), $urandom_range(0, 16383), 50);
      @(posedge p_clk); #1;
      force_full = 1'b0;
      @(negedge p_clk); #2;
      chk("t4_wreq_pre",  32'(bus.w_req), 1);
      chk("t4_level_pre", 32'(q_level), 3);
      rst = 1'b0;
      #1;
      chk("t4_wreq",   32'(bus.w_req), 0);
      chk("t4_level",  32'(q_level), 0);
      chk("t4_ready",  32'(bus.cmd_ready), 1);
      chk("t4_issued", 32'(issued_cnt), 0);
      exp_q.delete();
      @(posedge p_clk); #1;
      rst = 1'b1;
      push($urandom_range(0, 7), $urandom_range(0, 16383), $urandom_range(0, 16383), 50);
      drain("t4");
      chk("t4_issued1", 32'(issued_cnt), 1);

      // co-processor FIFO without reads, 40 commands
      n = 0;
      while (cf_cnt != 0 && n < 500) begin
         @(negedge p_clk);
         n++;
      end
      rd_en = 1'b0;
      w0 = cf_writes;
      i0 = issued_cnt;
      fork
         begin
            for (int k = 0; k < 40; k++)
               push($urandom_range(0, 7), $urandom_range(0, 16383), $urandom_range(0, 16383), 5000);
            host_done = 1'b1;
         end
      join_none
      n = 0;
      while (cf_writes - w0 < 32 && n < 2000) begin
         @(negedge p_clk);
         n++;
      end
      repeat (20) @(negedge p_clk);
      #2;
      chk("t5_writes32", 32'(cf_writes - w0), 32);
      chk("t5_cfcnt",    32'(cf_cnt), 32);
      chk("t5_qfull",    32'(q_level), 4);
      chk("t5_hold",     32'(bus.w_req), 0);
      rd_en = 1'b1;
      n = 0;
      while (!host_done && n < 4000) begin
         @(negedge p_clk);
         n++;
      end
      chk("t5_host_done", 32'(host_done), 1);
      drain("t5");
      chk("t5_writes40", 32'(cf_writes - w0), 40);
      chk("t5_overflow", 32'(cf_overflow), 0);
      chk("t5_issued",   32'(issued_cnt - i0), 40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
